vga_frame_sequencer: RTL and testbench
======================================

// Module: vga_frame_sequencer
// PURPOSE
// Per-frame parameter scheduler for the radial VGA demo datapath. Counts frames once per vsync and derives the
// animation offsets, center point and effect-mode bits. During vertical blanking it computes center_x^2 and
// center_y^2 by repeated addition, so the pixel datapath needs no multiplier to seed its incremental radius
// accumulators. It publishes one coherent parameter set before the first visible line. Sits between
// hvsync_generator and the pixel/colour datapath.
// PARAMETERS
// FRAME_BITS   12    frame counter width
// FRAME_RESET  300   frame counter value after reset
// BASE_X       320   horizontal center before offset
// BASE_Y       240   vertical center before offset
// PORTS
// clk          in   1   pixel clock, 25.175 MHz
// reset        in   1   synchronous, active-high
// vsync        in   1   from hvsync_generator
// frame        out  12  published frame counter
// center_x     out  10  BASE_X + frame[6:0]/2
// center_y     out  10  BASE_Y + frame[6:0]
// center_x_sq  out  18  center_x*center_x
// center_y_sq  out  18  center_y*center_y
// mode_a       out  1   frame[8]
// mode_b       out  1   frame[7]^frame[8]
// zoom_mode    out  1   frame[7]&frame[8]
// params_valid out  1   published set is coherent and stable
// BEHAVIOUR
// - One clock (clk); reset is synchronous and active-high. All outputs are registered.
// - Reset (any cycle, including mid-computation): working frame=FRAME_RESET, state=IDLE, params_valid=0.
//   All published outputs are 0 (frame=0, centers=0, squares=0, mode bits=0).
// - vsync_q is a registered copy of vsync. A rise is vsync & ~vsync_q in cycle T. Frame advances exactly once
//   per rise, however long vsync stays high. Frame wraps modulo 2^FRAME_BITS (4095 -> 0).
// - FSM states: IDLE, SQ_Y, SQ_X, PUBLISH.
//   - Rise in cycle T: working frame+1 is latched, and shadow cx/cy are computed from it. params_valid drops at
//     T+1. The FSM enters SQ_Y at T+1 with acc=0 and cnt=0.
//   - SQ_Y: acc+=cy and cnt+=1 each cycle; after cy additions, y_sq=acc and the FSM moves to SQ_X with acc/cnt
//     cleared.
//   - SQ_X: same with cx; after cx additions, the FSM moves to PUBLISH.
//   - PUBLISH (1 cycle): all published outputs are loaded together. params_valid=1 from the next cycle.
//     The FSM returns to IDLE.
//   - Latency: params_valid is first high at T+cy+cx+3. Worst case 383+367+3=753 cycles, less than 1 line.
// - Published outputs change only in PUBLISH. They never change while params_valid=1.
// - A rise while in SQ_Y or SQ_X aborts the computation. The FSM restarts in SQ_Y with the new frame, and the
//   aborted frame is never published. A rise in the PUBLISH cycle: publish completes, then the FSM restarts and
//   params_valid=0 again.
// - Arithmetic is unsigned. The offset is frame[6:0], so cx is 320..383 and cy is 240..367. acc is 18 bits with
//   no overflow (max 146689).
// STRUCTURE
// - Shared package vga_demo_pkg: H/V display/porch/sync constants, BASE_X/BASE_Y, state enum
//   {IDLE,SQ_Y,SQ_X,PUBLISH}, SQ_W=18.
// - One sub-module: seq_square (clk, reset, start, operand[9:0], busy, done, result[17:0]). It is an iterative
//   adder, one addition per cycle. It is instantiated once and reused for y then x. A start while busy restarts it.
// TESTING
// 1. Reset for 3 cycles -> params_valid=0, all published outputs 0; working frame 300.
// 2. First vsync rise at T (frame 301, offset 45) -> at T+630: params_valid=1, frame=301, center_x=342,
//    center_y=285, center_x_sq=116964, center_y_sq=81225, mode_a=1, mode_b=1, zoom_mode=0.
// 3. vsync held high 1600 cycles -> frame advances by exactly 1; outputs stable after publish.
// 4. FRAME_RESET=4095, one rise -> frame=0, center 320/240, squares 102400/57600, all modes 0.
// 5. Second rise 100 cycles after the first -> frame 302 is published (center 343/286, squares 117649/81796).
//    Frame 301 is never visible; valid at second-rise T+632.
// 6. reset asserted mid-SQ_X -> next cycle IDLE, params_valid=0, outputs 0. Next rise publishes frame 301.

Source files
------------

// File: rtl/vga_demo_pkg.sv
// Shared constants and types for the radial VGA demo: 640x480 timing, nominal
// screen center, frame-sequencer FSM states and squarer result width.
package vga_demo_pkg;

   localparam int H_DISPLAY = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_DISPLAY = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int BASE_X = 320;
   localparam int BASE_Y = 240;

   localparam int OP_W = 10;
   localparam int SQ_W = 18;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SQ_Y    = 2'd1,
      SQ_X    = 2'd2,
      PUBLISH = 2'd3
   } seq_state_t;

endpackage

// File: rtl/vga_frame_sequencer_square.sv
// Iterative squarer: adds operand to itself operand times, one addition per cycle.
// done pulses during the final addition; result is valid only in that cycle.
module seq_square
   import vga_demo_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [OP_W-1:0] operand,
   output logic            busy,
   output logic            done,
   output logic [SQ_W-1:0] result
);

   logic            busy_q, busy_d;
   logic [SQ_W-1:0] acc_q,  acc_d;
   logic [OP_W-1:0] cnt_q,  cnt_d;
   logic [OP_W-1:0] op_q,   op_d;
   logic            last;

   // Operand is latched at start so the caller may repoint its mux afterwards.
   assign last = busy_q && (cnt_q == op_q - OP_W'(1));

   always_comb begin
      busy_d = busy_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      op_d   = op_q;
      if (start) begin
         busy_d = 1'b1;
         acc_d  = '0;
         cnt_d  = '0;
         op_d   = operand;
      end else if (busy_q) begin
         acc_d = acc_q + SQ_W'(op_q);
         cnt_d = cnt_q + OP_W'(1);
         if (last) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         acc_q  <= '0;
         cnt_q  <= '0;
         op_q   <= '0;
      end else begin
         busy_q <= busy_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         op_q   <= op_d;
      end
   end

   assign busy   = busy_q;
   assign done   = last;
   assign result = acc_q + SQ_W'(op_q);

endmodule

// File: rtl/vga_frame_sequencer.sv
// Per-frame parameter scheduler: advances the frame on each vsync rise, squares the
// new center during blanking and publishes one coherent parameter set at a time.
module vga_frame_sequencer
   import vga_demo_pkg::*;
#(
   parameter int FRAME_BITS  = 12,
   parameter int FRAME_RESET = 300,
   parameter int BASE_X      = vga_demo_pkg::BASE_X,
   parameter int BASE_Y      = vga_demo_pkg::BASE_Y
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vsync,
   output logic [FRAME_BITS-1:0] frame,
   output logic [OP_W-1:0]       center_x,
   output logic [OP_W-1:0]       center_y,
   output logic [SQ_W-1:0]       center_x_sq,
   output logic [SQ_W-1:0]       center_y_sq,
   output logic                  mode_a,
   output logic                  mode_b,
   output logic                  zoom_mode,
   output logic                  params_valid
);

   seq_state_t            state_q, state_d;
   logic                  vsync_q;
   logic                  rise;
   logic [FRAME_BITS-1:0] frame_q, frame_next;
   logic [OP_W-1:0]       cx_q, cy_q, cx_new, cy_new;
   logic [SQ_W-1:0]       ysq_q, xsq_q;

   logic [FRAME_BITS-1:0] pub_frame_q;
   logic [OP_W-1:0]       pub_cx_q, pub_cy_q;
   logic [SQ_W-1:0]       pub_xsq_q, pub_ysq_q;
   logic                  pub_ma_q, pub_mb_q, pub_zm_q;
   logic                  valid_q;

   logic                  sq_start, sq_busy, sq_done;
   logic [OP_W-1:0]       sq_operand;
   logic [SQ_W-1:0]       sq_result;
   logic                  cap_y, cap_x, do_publish;

   assign rise       = vsync & ~vsync_q;
   assign frame_next = frame_q + FRAME_BITS'(1);
   assign cx_new     = OP_W'(BASE_X) + {4'd0, frame_next[6:1]};
   assign cy_new     = OP_W'(BASE_Y) + {3'd0, frame_next[6:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A rise preempts any state, so a stale computation is never published.
   always_comb begin
      state_d = state_q;
      if (rise) begin
         state_d = SQ_Y;
      end else begin
         unique case (state_q)
            IDLE:    state_d = IDLE;
            SQ_Y:    if (sq_done) state_d = SQ_X;
            SQ_X:    if (sq_done) state_d = PUBLISH;
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // X squaring kicks off in the first SQ_X cycle, once the Y pass has released the squarer.
   always_comb begin
      sq_start   = rise || ((state_q == SQ_X) && !sq_busy);
      sq_operand = rise ? cy_new : cx_q;
      cap_y      = !rise && (state_q == SQ_Y) && sq_done;
      cap_x      = !rise && (state_q == SQ_X) && sq_done;
      do_publish = (state_q == PUBLISH);
   end

   seq_square u_square (
      .clk     (clk),
      .reset   (reset),
      .start   (sq_start),
      .operand (sq_operand),
      .busy    (sq_busy),
      .done    (sq_done),
      .result  (sq_result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q     <= 1'b0;
         frame_q     <= FRAME_BITS'(FRAME_RESET);
         cx_q        <= '0;
         cy_q        <= '0;
         ysq_q       <= '0;
         xsq_q       <= '0;
         pub_frame_q <= '0;
         pub_cx_q    <= '0;
         pub_cy_q    <= '0;
         pub_xsq_q   <= '0;
         pub_ysq_q   <= '0;
         pub_ma_q    <= 1'b0;
         pub_mb_q    <= 1'b0;
         pub_zm_q    <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         vsync_q <= vsync;
         if (rise) begin
            frame_q <= frame_next;
            cx_q    <= cx_new;
            cy_q    <= cy_new;
         end
         if (cap_y) ysq_q <= sq_result;
         if (cap_x) xsq_q <= sq_result;
         if (do_publish) begin
            pub_frame_q <= frame_q;
            pub_cx_q    <= cx_q;
            pub_cy_q    <= cy_q;
            pub_xsq_q   <= xsq_q;
            pub_ysq_q   <= ysq_q;
            pub_ma_q    <= frame_q[8];
            pub_mb_q    <= frame_q[7] ^ frame_q[8];
            pub_zm_q    <= frame_q[7] & frame_q[8];
         end
         if (rise) begin
            valid_q <= 1'b0;
         end else if (do_publish) begin
            valid_q <= 1'b1;
         end
      end
   end

   assign frame        = pub_frame_q;
   assign center_x     = pub_cx_q;
   assign center_y     = pub_cy_q;
   assign center_x_sq  = pub_xsq_q;
   assign center_y_sq  = pub_ysq_q;
   assign mode_a       = pub_ma_q;
   assign mode_b       = pub_mb_q;
   assign zoom_mode    = pub_zm_q;
   assign params_valid = valid_q;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Scoreboard bench for vga_frame_sequencer: expected parameter sets are queued on each
// vsync rise and compared when params_valid rises; a second instance covers frame wrap.
module tb_vga_frame_sequencer;
   import vga_demo_pkg::*;

   typedef struct packed {
      logic [11:0] frame;
      logic [9:0]  cx;
      logic [9:0]  cy;
      logic [17:0] cxs;
      logic [17:0] cys;
      logic        ma;
      logic        mb;
      logic        zm;
   } pset_t;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic reset = 1'b1;
   logic vsync = 1'b0;
   logic vsync2 = 1'b0;

   logic [11:0] frame1, frame2;
   logic [9:0]  cx1, cy1, cx2, cy2;
   logic [17:0] cxs1, cys1, cxs2, cys2;
   logic        ma1, mb1, zm1, valid1;
   logic        ma2, mb2, zm2, valid2;

   vga_frame_sequencer dut (
      .clk(clk), .reset(reset), .vsync(vsync),
      .frame(frame1), .center_x(cx1), .center_y(cy1),
      .center_x_sq(cxs1), .center_y_sq(cys1),
      .mode_a(ma1), .mode_b(mb1), .zoom_mode(zm1), .params_valid(valid1)
   );

   vga_frame_sequencer #(.FRAME_RESET(4095)) dut_wrap (
      .clk(clk), .reset(reset), .vsync(vsync2),
      .frame(frame2), .center_x(cx2), .center_y(cy2),
      .center_x_sq(cxs2), .center_y_sq(cys2),
      .mode_a(ma2), .mode_b(mb2), .zoom_mode(zm2), .params_valid(valid2)
   );

   int    vectors = 0;
   int    miscompares = 0;
   int    wf;
   pset_t exp_q[$];
   int    lat_q[$];

   function automatic pset_t model(input int f);
      pset_t       p;
      logic [11:0] fv;
      int          off, x, y;
      fv  = 12'(f);
      off = f % 128;
      x   = 320 + off / 2;
      y   = 240 + off;
      p.frame = fv;
      p.cx    = 10'(x);
      p.cy    = 10'(y);
      p.cxs   = 18'(x * x);
      p.cys   = 18'(y * y);
      p.ma    = fv[8];
      p.mb    = fv[7] ^ fv[8];
      p.zm    = fv[7] & fv[8];
      return p;
   endfunction

   function automatic int model_lat(input int f);
      int off;
      off = f % 128;
      return (320 + off / 2) + (240 + off) + 3;
   endfunction

   function automatic pset_t obs1();
      pset_t p;
      p = '{frame1, cx1, cy1, cxs1, cys1, ma1, mb1, zm1};
      return p;
   endfunction

   function automatic pset_t obs2();
      pset_t p;
      p = '{frame2, cx2, cy2, cxs2, cys2, ma2, mb2, zm2};
      return p;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Raises vsync in the current cycle (T) and queues the set that rise should publish.
   task automatic push_rise();
      wf = (wf + 1) % 4096;
      exp_q.push_back(model(wf));
      lat_q.push_back(model_lat(wf));
      vsync = 1'b1;
   endtask

   task automatic wait_valid1(input int hold, input int start, output int lat);
      lat = start;
      while (lat < 2000) begin
         cycle();
         lat++;
         if (lat == hold) vsync = 1'b0;
         if (valid1) break;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      vsync = 1'b0;
      vsync2 = 1'b0;
      repeat (3) cycle();
      vectors++;
      if (valid1 !== 1'b0 || valid2 !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid: got %b/%b want 0/0", valid1, valid2);
      end
      vectors++;
      if (obs1() !== '0 || obs2() !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h / %h want 0", obs1(), obs2());
      end
      vectors++;
      if (dut.state_q !== IDLE) begin
         miscompares++;
         $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
      end
      reset = 1'b0;
      wf = 300;
   endtask

   task automatic test_first_frame();
      int    lat, el;
      pset_t e;
      push_rise();
      wait_valid1(4, 0, lat);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      vectors++;
      if (lat !== el) begin
         miscompares++;
         $display("FAIL first_latency: got %0d want %0d", lat, el);
      end
      vectors++;
      if (obs1() !== e) begin
         miscompares++;
         $display("FAIL first_params: got %h want %h", obs1(), e);
      end
      vectors++;
      if (frame1 !== 12'd301 || cxs1 !== 18'd116964 || cys1 !== 18'd81225) begin
         miscompares++;
         $display("FAIL first_const: got %0d %0d %0d want 301 116964 81225", frame1, cxs1, cys1);
      end
   endtask

   task automatic test_vsync_hold();
      int    lat, el;
      pset_t e, snap;
      bit    stable;
      push_rise();
      vectors++;
      if (valid1 !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_valid_at_T: got %b want 1", valid1);
      end
      cycle();
      vectors++;
      if (valid1 !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_valid_drop: got %b want 0", valid1);
      end
      wait_valid1(1600, 1, lat);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      vectors++;
      if (lat !== el) begin
         miscompares++;
         $display("FAIL hold_latency: got %0d want %0d", lat, el);
      end
      vectors++;
      if (obs1() !== e) begin
         miscompares++;
         $display("FAIL hold_params: got %h want %h", obs1(), e);
      end
      snap = e;
      stable = 1'b1;
      for (int i = lat; i < 1600; i++) begin
         cycle();
         if (obs1() !== snap || valid1 !== 1'b1) stable = 1'b0;
      end
      vectors++;
      if (stable !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_stable: got %b want 1", stable);
      end
      vsync = 1'b0;
      repeat (800) cycle();
      vectors++;
      if (obs1() !== snap || valid1 !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_single_advance: got %h/%b want %h/1", obs1(), valid1, snap);
      end
   endtask

   task automatic test_back_to_back();
      int    lat, el;
      pset_t e;
      bit    leaked;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      wf = 301;
      vsync = 1'b1;
      leaked = 1'b0;
      for (int i = 1; i < 100; i++) begin
         cycle();
         if (i == 3) vsync = 1'b0;
         if (valid1) leaked = 1'b1;
      end
      cycle();
      push_rise();
      wait_valid1(3, 0, lat);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      vectors++;
      if (leaked !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_aborted_visible: got %b want 0", leaked);
      end
      vectors++;
      if (lat !== el || lat !== 632) begin
         miscompares++;
         $display("FAIL b2b_latency: got %0d want %0d", lat, el);
      end
      vectors++;
      if (obs1() !== e || cx1 !== 10'd343 || cys1 !== 18'd81796) begin
         miscompares++;
         $display("FAIL b2b_params: got %h want %h", obs1(), e);
      end
   endtask

   task automatic test_reset_mid_sqx();
      int    lat, el;
      pset_t e;
      wf = 303;
      vsync = 1'b1;
      for (int i = 1; i <= 287 + 50; i++) begin
         cycle();
         if (i == 3) vsync = 1'b0;
      end
      vectors++;
      if (valid1 !== 1'b0 || dut.state_q !== SQ_X) begin
         miscompares++;
         $display("FAIL midx_precondition: got valid %b state %0d want 0 %0d", valid1, dut.state_q, SQ_X);
      end
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      vectors++;
      if (valid1 !== 1'b0 || obs1() !== '0 || dut.state_q !== IDLE) begin
         miscompares++;
         $display("FAIL midx_reset: got %b %h %0d want 0 0 %0d", valid1, obs1(), dut.state_q, IDLE);
      end
      wf = 300;
      cycle();
      push_rise();
      wait_valid1(3, 0, lat);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      vectors++;
      if (lat !== el || obs1() !== e) begin
         miscompares++;
         $display("FAIL midx_republish: got %0d %h want %0d %h", lat, obs1(), el, e);
      end
   endtask

   task automatic test_wrap();
      int    lat;
      pset_t e;
      e = model(0);
      vsync2 = 1'b1;
      lat = 0;
      while (lat < 2000) begin
         cycle();
         lat++;
         if (lat == 3) vsync2 = 1'b0;
         if (valid2) break;
      end
      vectors++;
      if (lat !== model_lat(0)) begin
         miscompares++;
         $display("FAIL wrap_latency: got %0d want %0d", lat, model_lat(0));
      end
      vectors++;
      if (obs2() !== e || cxs2 !== 18'd102400 || cys2 !== 18'd57600) begin
         miscompares++;
         $display("FAIL wrap_params: got %h want %h", obs2(), e);
      end
   endtask

   initial begin
      test_reset();
      cycle();
      test_first_frame();
      repeat (50) cycle();
      test_vsync_hold();
      test_back_to_back();
      test_reset_mid_sqx();
      test_wrap();
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
